// File: rtl/int2fp16_stream_sequencer.sv
// int2fp16_stream_sequencer
// Captures one packed beat of NUM_IN small signed integers and replays it as
// NUM_IN/NUM_LANES output beats. Each output beat carries NUM_LANES exact fp16
// conversions. A narrow converter bank can therefore serve a wide integer
// stream at one output beat per cycle. When the last chunk drains, the next
// input beat can load in the same cycle, so no bubble appears between beats.
module int2fp16_stream_sequencer #(
    parameter int INT_WIDTH = 4,
    parameter int NUM_IN    = 8,
    parameter int NUM_LANES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic [NUM_IN*INT_WIDTH-1:0]   in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [NUM_LANES*16-1:0]       out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_last_o,
    output logic                          busy_o,
    output logic [31:0]                   beat_cnt_o
);

    localparam int NCHUNK = NUM_IN / NUM_LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    // Reject parameter sets the chunking scheme cannot represent.
    generate
        if ((NUM_IN % NUM_LANES) != 0) begin : g_bad_ratio
            $error("NUM_IN must be a multiple of NUM_LANES");
        end
        if ((INT_WIDTH < 1) || (INT_WIDTH > 4)) begin : g_bad_width
            $error("INT_WIDTH must be in 1..4");
        end
    endgenerate

    logic [0:0]                  state_reg;
    logic [CW-1:0]               chunk_reg;
    logic [NUM_IN*INT_WIDTH-1:0] buffer_reg;
    logic [31:0]                 beat_cnt_reg;

    logic conv_active;
    logic at_last;
    logic in_fire;
    logic out_fire;

    // Exact int -> fp16. Magnitudes never exceed 8, so the mantissa is a plain
    // left shift and no rounding is ever needed.
    function automatic logic [15:0] to_fp16(input logic [INT_WIDTH-1:0] x);
        logic                 sign;
        logic [INT_WIDTH:0]   ext;
        logic [INT_WIDTH:0]   mag;
        logic [3:0]           mag4;
        logic [1:0]           p;
        logic [15:0]          shifted;
        logic [4:0]           exp_f;
        logic [15:0]          result;
        // Width 1 is unsigned {0,1}. Wider elements are two's complement.
        sign    = (INT_WIDTH > 1) ? x[INT_WIDTH-1] : 1'b0;
        ext     = {sign, x};
        mag     = sign ? (~ext + 1'b1) : ext;
        mag4    = 4'(mag);
        casez (mag4)
            4'b1???: p = 2'd3;
            4'b01??: p = 2'd2;
            4'b001?: p = 2'd1;
            default: p = 2'd0;
        endcase
        shifted = 16'(mag4) << (4'd10 - {2'b00, p});
        exp_f   = 5'd15 + {3'b000, p};
        if (mag4 == 4'd0) begin
            result = 16'h0000;
        end else begin
            result = {sign, exp_f, shifted[9:0]};
        end
        return result;
    endfunction

    assign conv_active = (state_reg == ST_CONV);
    assign at_last     = conv_active && (chunk_reg == LAST_CHUNK);

    // The next beat may load as the final chunk leaves. A clear suppresses all handshakes.
    assign in_ready_o  = !clear_i && (!conv_active || (at_last && out_ready_i));
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = conv_active && out_ready_i && !clear_i;

    assign out_valid_o = conv_active;
    assign out_last_o  = at_last;
    assign busy_o      = conv_active;
    assign beat_cnt_o  = beat_cnt_reg;

    // Arrange the buffered elements by chunk and lane, so each lane uses one
    // mux indexed by the chunk counter.
    logic [INT_WIDTH-1:0] chunk_elem [NCHUNK][NUM_LANES];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            for (gj = 0; gj < NUM_LANES; gj++) begin : g_elem
                assign chunk_elem[gi][gj] =
                    buffer_reg[(gi*NUM_LANES + gj)*INT_WIDTH +: INT_WIDTH];
            end
        end

        for (gj = 0; gj < NUM_LANES; gj++) begin : g_lane
            logic [15:0] lane_fp;
            // Lane converter: element chunk*NUM_LANES+j, purely from registers.
            always_comb begin
                lane_fp = to_fp16(chunk_elem[chunk_reg][gj]);
            end
            assign out_data_o[gj*16 +: 16] = conv_active ? lane_fp : 16'h0000;
        end
    endgenerate

    // Sequencer FSM: capture a beat, step through its chunks, then reload or go idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            chunk_reg  <= '0;
            buffer_reg <= '0;
        end else if (clear_i) begin
            state_reg  <= ST_IDLE;
            chunk_reg  <= '0;
        end else if (in_fire) begin
            // Covers the idle load and the back-to-back reload on the last chunk.
            buffer_reg <= in_data_i;
            chunk_reg  <= '0;
            state_reg  <= ST_CONV;
        end else if (out_fire) begin
            if (at_last) begin
                state_reg <= ST_IDLE;
                chunk_reg <= '0;
            end else begin
                chunk_reg <= chunk_reg + 1'b1;
            end
        end
    end

    // Completed-beat counter. It wraps naturally at 2^32 and is untouched by clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_reg <= '0;
        end else if (out_fire && at_last) begin
            beat_cnt_reg <= beat_cnt_reg + 32'd1;
        end
    end

endmodule

// File: tb/tb_int2fp16_stream_sequencer.sv
// Testbench for int2fp16_stream_sequencer. A queue-based model predicts every
// output beat, using an fp16 encoding derived from the IEEE double bits.
// Directed cases pin exact literal values.
module tb_int2fp16_stream_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance: default parameters.
    logic        clear, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_data, out_data, beat_cnt;

    // Secondary instance: unsigned 1-bit elements.
    logic        clear1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
    logic [7:0]  in_data1;
    logic [31:0] out_data1, beat_cnt1;

    int2fp16_stream_sequencer #(.INT_WIDTH(4), .NUM_IN(8), .NUM_LANES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last), .busy_o(busy), .beat_cnt_o(beat_cnt)
    );

    int2fp16_stream_sequencer #(.INT_WIDTH(1), .NUM_IN(8), .NUM_LANES(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1),
        .in_data_i(in_data1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .out_data_o(out_data1), .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .out_last_o(out_last1), .busy_o(busy1), .beat_cnt_o(beat_cnt1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [31:0] exp_cnt;
    logic        m_v, m_ir;

    // fp16 taken from the double-precision encoding: rebias the exponent and keep the top 10 fraction bits.
    function automatic logic [15:0] ref_fp16(input int v);
        real         r;
        logic [63:0] b;
        logic [10:0] e;
        if (v == 0) return 16'h0000;
        r = v;
        b = $realtobits(r);
        e = b[62:52];
        return {b[63], 5'(e - 11'd1008), b[51:42]};
    endfunction

    function automatic int elem4(input logic [31:0] d, input int k);
        logic [3:0] n;
        n = d[k*4 +: 4];
        return n[3] ? int'(n) - 16 : int'(n);
    endfunction

    task automatic model_push(input logic [31:0] d);
        beat_t b;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 2; j++) begin
                b.data[j*16 +: 16] = ref_fp16(elem4(d, c*2 + j));
            end
            b.last = (c == 3);
            q.push_back(b);
        end
    endtask

    // Per-cycle compare of the main instance against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = 32'd0;
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_beat_cnt", beat_cnt, 32'd0);
            check("rst_out_data", out_data, 32'd0);
        end else begin
            m_v  = (q.size() > 0);
            m_ir = !clear && (!m_v || (q[0].last && out_ready));
            check("out_valid", {31'd0, out_valid}, {31'd0, m_v});
            check("busy", {31'd0, busy}, {31'd0, m_v});
            check("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
            check("beat_cnt", beat_cnt, exp_cnt);
            if (m_v) begin
                check("out_data", out_data, q[0].data);
                check("out_last", {31'd0, out_last}, {31'd0, q[0].last});
            end
            if (clear) begin
                q.delete();
            end else begin
                if (m_v && out_ready) begin
                    if (q[0].last) exp_cnt = exp_cnt + 32'd1;
                    void'(q.pop_front());
                end
                if (in_valid && m_ir) model_push(in_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    logic [31:0] exp_c [4];
    int          waited;

    initial begin
        exp_a = '{32'h4000_3C00, 32'h4400_4200, 32'h4600_4500, 32'hC800_4700};
        exp_b = '{32'hBC00_0000, 32'hC200_0000, 32'h0000_0000, 32'h0000_0000};
        exp_c = '{32'h3C00_3C00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        rst_n = 1'b0;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

        // Pin the model's conversion with a few hand-computed values.
        check("ref_fp16(-8)", {16'd0, ref_fp16(-8)}, 32'h0000_C800);
        check("ref_fp16(5)",  {16'd0, ref_fp16(5)},  32'h0000_4500);
        check("ref_fp16(-3)", {16'd0, ref_fp16(-3)}, 32'h0000_C200);

        // Reset held three cycles, released mid-cycle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_beat_cnt", beat_cnt, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // Beat 87654321 with out_ready held high.
        @(posedge clk); #1 in_data = 32'h8765_4321; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("basic_beat%0d", k), out_data, exp_a[k]);
            check($sformatf("basic_last%0d", k), {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("basic_idle", {31'd0, out_valid}, 32'd0);
        check("basic_cnt", beat_cnt, 32'd1);

        // Negative elements and zeros.
        @(posedge clk); #1 in_data = 32'h0000_D0F0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("neg_beat%0d", k), out_data, exp_b[k]);
        end
        @(negedge clk);
        check("neg_cnt", beat_cnt, 32'd2);

        // Hold out_ready low for five cycles while chunk 1 is presented.
        @(posedge clk); #1 in_data = 32'h8765_4321; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_data", out_data, 32'h4400_4200);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_last", {31'd0, out_last}, 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        waited = 0;
        while (out_valid && waited < 20) begin
            @(posedge clk); #1 waited++;
        end
        check("bp_drain_timeout", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("bp_cnt", beat_cnt, 32'd3);

        // Two beats back to back, with in_valid held high.
        @(posedge clk); #1 in_data = $urandom; in_valid = 1'b1;
        @(posedge clk); #1 in_data = $urandom;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_no_gap", {31'd0, out_valid}, 32'd1);
            if (i == 3) begin
                check("b2b_in_ready_on_last", {31'd0, in_ready}, 32'd1);
                check("b2b_last", {31'd0, out_last}, 32'd1);
            end
            @(posedge clk); #1;
            if (i == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle", {31'd0, out_valid}, 32'd0);
        check("b2b_cnt", beat_cnt, 32'd5);

        // Clear on chunk 2, with a competing input handshake that must be ignored.
        @(posedge clk); #1 in_data = 32'h8765_4321; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 clear = 1'b1; in_valid = 1'b1; in_data = 32'h1111_1111;
        @(negedge clk);
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_cnt", beat_cnt, 32'd5);
        repeat (3) begin
            @(negedge clk);
            check("clr_quiet", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset in the middle of a beat.
        @(posedge clk); #1 in_data = 32'h8765_4321; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_data", out_data, 32'd0);
        check("arst_cnt", beat_cnt, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_quiet", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic with backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 29) == 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("rand_drained", {31'd0, out_valid}, 32'd0);

        // 1-bit unsigned instance.
        @(posedge clk); #1 in_data1 = 8'b0000_0011; in_valid1 = 1'b1;
        @(posedge clk); #1 in_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("w1_beat%0d", k), out_data1, exp_c[k]);
            check($sformatf("w1_valid%0d", k), {31'd0, out_valid1}, 32'd1);
            check($sformatf("w1_last%0d", k), {31'd0, out_last1}, (k == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("w1_cnt", beat_cnt1, 32'd1);
        check("w1_idle", {31'd0, out_valid1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
